// File: rtl/seg7_scan_driver.sv
// Eight-digit common-anode seven-segment scanner: snapshots the display word once per frame,
// then multiplexes digits with an anti-ghost gap, PWM brightness and per-digit blinking.
module seg7_scan_driver #(
    parameter int unsigned REFRESH_DIV  = 100000,
    parameter int unsigned GHOST_CYCLES = 1000,
    parameter int unsigned BLINK_DIV    = 25000000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] display_data,
    input  logic        enable,
    input  logic [2:0]  brightness,
    input  logic [7:0]  blink_mask,
    output logic [7:0]  an,
    output logic [6:0]  seg,
    output logic        dp
);

    localparam int unsigned SW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int unsigned BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    localparam logic [SW-1:0] SLOT_LAST  = SW'(REFRESH_DIV - 1);
    localparam logic [SW-1:0] SLOT_GHOST = SW'(GHOST_CYCLES);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

    logic [SW-1:0] slot_cnt;
    logic [2:0]    digit_idx;
    logic [2:0]    pwm_cnt;
    logic [BW-1:0] blink_cnt;
    logic          blink_phase;
    logic [31:0]   frame_data;

    logic [3:0]    nib;
    logic          blank;
    logic          lit;
    logic          slot_wrap;
    logic          blink_wrap;
    logic          frame_start;
    logic [7:0]    an_next;
    logic [6:0]    seg_next;

    function automatic logic [6:0] decode(input logic [3:0] code);
        logic [6:0] s;
        s = 7'b1111111;
        case (code)
            4'h0: s = 7'b1000000;
            4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;
            4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;
            4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;
            4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0010000;
            4'hC: s = 7'b1000110;
            4'hD: s = 7'b0100001;
            4'hE: s = 7'b0000110;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    assign dp = 1'b1;

    // Everything here is derived from pre-update state, so same-cycle wraps/snapshot don't bleed in.
    always_comb begin
        nib         = frame_data[{digit_idx, 2'b00} +: 4];
        blank       = (nib == 4'hA) || (nib == 4'hB) || (nib == 4'hF);
        slot_wrap   = (slot_cnt == SLOT_LAST);
        blink_wrap  = (blink_cnt == BLINK_LAST);
        frame_start = (digit_idx == 3'd0) && (slot_cnt == '0);
        lit         = enable
                      && (slot_cnt >= SLOT_GHOST)
                      && !blank
                      && (pwm_cnt <= brightness)
                      && !(blink_mask[digit_idx] && blink_phase);
        an_next     = 8'hFF;
        seg_next    = 7'h7F;
        if (lit) begin
            an_next  = ~(8'b0000_0001 << digit_idx);
            seg_next = decode(nib);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            slot_cnt    <= '0;
            digit_idx   <= '0;
            pwm_cnt     <= '0;
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
            frame_data  <= '1;
            an          <= 8'hFF;
            seg         <= 7'h7F;
        end else begin
            an  <= an_next;
            seg <= seg_next;

            if (frame_start) begin
                frame_data <= display_data;
            end

            if (slot_wrap) begin
                slot_cnt  <= '0;
                digit_idx <= (digit_idx == 3'd7) ? 3'd0 : digit_idx + 3'd1;
            end else begin
                slot_cnt <= slot_cnt + SW'(1);
            end

            pwm_cnt <= (pwm_cnt == 3'd7) ? 3'd0 : pwm_cnt + 3'd1;

            if (blink_wrap) begin
                blink_cnt   <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                blink_cnt <= blink_cnt + BW'(1);
            end
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver: directed scenarios plus randomized traffic, checked every cycle
// against a time-indexed behavioural model of the scan.
module tb_seg7_scan_driver;

    localparam int unsigned R = 16;
    localparam int unsigned G = 2;
    localparam int unsigned B = 64;
    localparam int unsigned FRAME = 8 * R;

    localparam logic [6:0] FONT [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h7F, 7'h7F, 7'h46, 7'h21, 7'h06, 7'h7F
    };

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] display_data;
    logic        enable;
    logic [2:0]  brightness;
    logic [7:0]  blink_mask;
    logic [7:0]  an;
    logic [6:0]  seg;
    logic        dp;

    int unsigned vectors = 0;
    int unsigned miscompares = 0;

    // Model state: t = clock edges since reset release; mframe = word latched at last frame start.
    int unsigned t;
    logic [31:0] mframe;
    logic [7:0]  exp_an;
    logic [6:0]  exp_seg;

    seg7_scan_driver #(
        .REFRESH_DIV (R),
        .GHOST_CYCLES(G),
        .BLINK_DIV   (B)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .display_data(display_data),
        .enable      (enable),
        .brightness  (brightness),
        .blink_mask  (blink_mask),
        .an          (an),
        .seg         (seg),
        .dp          (dp)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] want);
        vectors++;
        assert (got === want) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h (t=%0d)", tag, got, want, t);
        end
    endtask

    task automatic model_edge();
        int unsigned slot, dig, pwm, phase;
        logic [3:0] nib;
        logic lit;
        if (!rst_n) begin
            t       = 0;
            mframe  = 32'hFFFF_FFFF;
            exp_an  = 8'hFF;
            exp_seg = 7'h7F;
        end else begin
            slot  = t % R;
            dig   = (t / R) % 8;
            pwm   = t % 8;
            phase = (t / B) % 2;
            nib   = mframe[dig*4 +: 4];
            lit   = enable && (slot >= G) && !(nib inside {4'hA, 4'hB, 4'hF})
                    && (pwm <= brightness) && !(blink_mask[dig] && phase == 1);
            exp_an  = lit ? ~(8'h01 << dig) : 8'hFF;
            exp_seg = lit ? FONT[nib] : 7'h7F;
            if (t % FRAME == 0) mframe = display_data;
            t++;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check("an", an, exp_an);
        check("seg", {1'b0, seg}, {1'b0, exp_seg});
        check("dp", {7'b0, dp}, 8'h01);
    endtask

    task automatic run(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) tick();
    endtask

    task automatic run_to(input int unsigned pos);
        for (int unsigned i = 0; i < 4 * FRAME && (t % FRAME) != pos; i++) tick();
    endtask

    initial begin
        rst_n        = 1'b0;
        display_data = 32'h1234_5678;
        enable       = 1'b1;
        brightness   = 3'd7;
        blink_mask   = 8'h00;
        t            = 0;
        mframe       = 32'hFFFF_FFFF;

        // Reset held, then first lit digit appears three cycles after release
        run(5);
        rst_n = 1'b1;
        run(2);
        check("rel_dark", an, 8'hFF);
        tick();
        check("rel_an", an, 8'hFE);
        check("rel_seg", {1'b0, seg}, 8'h00);
        run_to(0);

        // Idle word
        display_data = 32'hFFFF_FF00;
        run(2 * FRAME);

        // Anti-tear: change during digit-0 slot of a frame
        display_data = 32'hFFFF_FF12;
        run_to(0);
        run(5);
        display_data = 32'hFFFF_FF34;
        run_to(R + 8);
        check("tear_an", an, 8'hFD);
        check("tear_seg", {1'b0, seg}, 8'h79);
        run_to(0);
        run(FRAME);

        // Decode of letters and blanks
        display_data = 32'hCDFF_ABF5;
        run(2 * FRAME);

        // PWM duty
        display_data = 32'h8888_8888;
        brightness = 3'd3;
        run(FRAME);
        brightness = 3'd0;
        run(FRAME);
        brightness = 3'd7;

        // Blink and reset mid digit-6 slot
        display_data = 32'hEEEF_FF42;
        blink_mask   = 8'hE0;
        run(3 * FRAME);
        run_to(6 * R + 5);
        rst_n = 1'b0;
        tick();
        check("rst_dark", an, 8'hFF);
        tick();
        rst_n = 1'b1;
        run(2 * FRAME);

        // Enable gating
        enable = 1'b0;
        run(FRAME / 2);
        enable = 1'b1;

        // Randomized traffic
        for (int unsigned i = 0; i < 20 * FRAME; i++) begin
            if ($urandom_range(0, 19) == 0) display_data = $urandom;
            if ($urandom_range(0, 39) == 0) brightness = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 49) == 0) blink_mask = 8'($urandom);
            if ($urandom_range(0, 59) == 0) enable = ~enable;
            if (rst_n == 1'b0) rst_n = 1'b1;
            else if ($urandom_range(0, 299) == 0) rst_n = 1'b0;
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
